// File: rtl/mul_div_unit_pkg.sv
// Shared opcodes, FSM encoding and signedness helper for the iterative
// multiply/divide unit.
package mdu_pkg;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } mdu_state_e;

  // rs2_op=0 asks about Rs1, rs2_op=1 about Rs2
  function automatic logic is_signed_op(
    input logic [2:0] f3,
    input logic       rs2_op
  );
    logic s;
    if (rs2_op)
      s = (f3 == MDU_MULH) || (f3 == MDU_DIV) ||
          (f3 == MDU_REM);
    else
      s = (f3 == MDU_MULH) || (f3 == MDU_MULHSU) ||
          (f3 == MDU_DIV)  || (f3 == MDU_REM);
    return s;
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the execute stage and the
// multiply/divide unit.
interface mul_div_unit_if #(
  parameter int XLEN = 32
) ();

  logic            Valid_in;
  logic            Ready_out;
  logic [XLEN-1:0] Rs1;
  logic [XLEN-1:0] Rs2;
  logic [2:0]      Funct3;
  logic            Flush;
  logic            Valid_out;
  logic            Ready_in;
  logic [XLEN-1:0] Result;
  logic            Busy;

  modport master (
    output Valid_in, Rs1, Rs2, Funct3, Flush, Ready_in,
    input  Ready_out, Valid_out, Result, Busy
  );

  modport slave (
    input  Valid_in, Rs1, Rs2, Funct3, Flush, Ready_in,
    output Ready_out, Valid_out, Result, Busy
  );

endinterface

// File: rtl/mul_div_unit_sign_fix.sv
// Conditional two's-complement negate; inc_i lets the upper half of a
// wide negation take the carry out of the lower half.
module mdu_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] mag_i,
  input  logic         neg_i,
  input  logic         inc_i,
  output logic [W-1:0] res_o
);

  assign res_o = neg_i ? (~mag_i + {{(W-1){1'b0}}, inc_i})
                       : mag_i;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M/RV64M multiply/divide unit (shift-add / restoring).
// Define MDU_FAST_PATH_EN to finish trivial cases in one cycle.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input logic           CLK,
  input logic           rst_n,
  mul_div_unit_if.slave bus
);

  mdu_state_e        state_q;
  logic [2:0]        f3_q;
  logic [XLEN-1:0]   b_q;
  logic [XLEN-1:0]   res_q;
  logic [2*XLEN-1:0] prod_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              neg_q;

  logic              s1, s2, dz, neg_d, fast;
  logic [XLEN-1:0]   abs_a, abs_b, fast_res;

  assign s1 = is_signed_op(bus.Funct3, 1'b0)
            & bus.Rs1[XLEN-1];
  assign s2 = is_signed_op(bus.Funct3, 1'b1)
            & bus.Rs2[XLEN-1];
  assign dz = (bus.Rs2 == '0);

  mdu_sign_fix #(.W(XLEN)) u_abs_a (
    .mag_i (bus.Rs1),
    .neg_i (s1),
    .inc_i (1'b1),
    .res_o (abs_a)
  );

  mdu_sign_fix #(.W(XLEN)) u_abs_b (
    .mag_i (bus.Rs2),
    .neg_i (s2),
    .inc_i (1'b1),
    .res_o (abs_b)
  );

  // Divide-by-zero quotient is all ones, so it must never be negated
  always_comb begin
    if (!bus.Funct3[2])
      neg_d = s1 ^ s2;
    else if (!bus.Funct3[1])
      neg_d = (s1 ^ s2) & ~dz;
    else
      neg_d = s1;
  end

  logic [XLEN-1:0] hi, lo;
  logic [XLEN:0]   sum, shl, diff;

  assign hi   = prod_q[2*XLEN-1:XLEN];
  assign lo   = prod_q[XLEN-1:0];
  assign sum  = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
  assign shl  = {hi, lo[XLEN-1]};
  assign diff = shl - {1'b0, b_q};

  logic [2*XLEN-1:0] step;

  always_comb begin
    if (!f3_q[2])
      step = {sum, lo[XLEN-1:1]};
    else if (diff[XLEN])
      step = {shl[XLEN-1:0], lo[XLEN-2:0], 1'b0};
    else
      step = {diff[XLEN-1:0], lo[XLEN-2:0], 1'b1};
  end

  logic [XLEN-1:0] fhi, flo, mag, res_fix;
  logic            inc;

  assign fhi = step[2*XLEN-1:XLEN];
  assign flo = step[XLEN-1:0];

  // Negating the high product half borrows the low half's carry
  always_comb begin
    mag = fhi;
    inc = 1'b1;
    unique case (1'b1)
      (f3_q == MDU_MUL):
        mag = flo;
      (!f3_q[2] && f3_q[1:0] != 2'b00): begin
        mag = fhi;
        inc = (flo == '0);
      end
      (f3_q[2] && !f3_q[1]):
        mag = flo;
      default:
        mag = fhi;
    endcase
  end

  mdu_sign_fix #(.W(XLEN)) u_res (
    .mag_i (mag),
    .neg_i (neg_q),
    .inc_i (inc),
    .res_o (res_fix)
  );

`ifdef MDU_FAST_PATH_EN
  logic ovf;

  assign ovf = bus.Funct3[2] & ~bus.Funct3[0]
             & (bus.Rs1 == {1'b1, {(XLEN-1){1'b0}}})
             & (&bus.Rs2);

  always_comb begin
    fast     = 1'b0;
    fast_res = '0;
    if (bus.Funct3[2]) begin
      if (dz) begin
        fast     = 1'b1;
        fast_res = bus.Funct3[1] ? bus.Rs1 : '1;
      end else if (ovf) begin
        fast     = 1'b1;
        fast_res = bus.Funct3[1] ? '0 : bus.Rs1;
      end
    end else if (bus.Rs1 == '0 || dz) begin
      fast = 1'b1;
    end
  end
`else
  assign fast     = 1'b0;
  assign fast_res = '0;
`endif

  assign bus.Ready_out = (state_q == IDLE);
  assign bus.Valid_out = (state_q == DONE);
  assign bus.Busy      = (state_q != IDLE);
  assign bus.Result    = res_q;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      f3_q    <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
    end else if (bus.Flush) begin
      state_q <= IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.Valid_in) begin
            f3_q   <= bus.Funct3;
            b_q    <= abs_b;
            prod_q <= {{XLEN{1'b0}}, abs_a};
            neg_q  <= neg_d;
            cnt_q  <= CNT_W'(XLEN);
            if (fast) begin
              state_q <= DONE;
              res_q   <= fast_res;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          prod_q <= step;
          cnt_q  <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= DONE;
            res_q   <= res_fix;
          end
        end
        DONE: begin
          if (bus.Ready_in)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed corner cases plus
// randomized operations checked against a plain-arithmetic model.
module tb_mul_div_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [31:0] exp_q[$];

  mul_div_unit_if #(.XLEN(32)) bus ();

  mul_div_unit #(.XLEN(32)) dut (
    .CLK   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model(
    input logic [2:0]  f,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [63:0] ea, eb, p;
    int          sa, sb;
    logic        ovf;
    ea  = (f == 3'd1 || f == 3'd2) ? {{32{a[31]}}, a}
                                   : {32'h0, a};
    eb  = (f == 3'd1) ? {{32{b[31]}}, b} : {32'h0, b};
    p   = ea * eb;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0:    return p[31:0];
      3'd1,
      3'd2,
      3'd3:    return p[63:32];
      3'd4:    return (b == 0) ? 32'hFFFF_FFFF :
                      ovf ? a : 32'(sa / sb);
      3'd5:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6:    return (b == 0) ? a :
                      ovf ? 32'h0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.Valid_out && bus.Ready_in && !bus.Flush) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %h expected none",
                 bus.Result);
      end else begin
        chk("result", bus.Result, exp_q.pop_front());
      end
    end
  end

  task automatic issue(
    input logic [2:0]  f,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] e,
    input bit          push
  );
    int n;
    n = 0;
    while (!bus.Ready_out && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got busy expected ready");
    end
    bus.Valid_in = 1'b1;
    bus.Funct3   = f;
    bus.Rs1      = a;
    bus.Rs2      = b;
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.Valid_in = 1'b0;
    bus.Rs1      = $urandom;
    bus.Rs2      = $urandom;
    bus.Funct3   = 3'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0",
               exp_q.size());
    end
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 9))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
  } vec_t;

  vec_t dir[$];
  bit   bp_stop;

  initial begin
    int          first;
    bit          busy_ok, stall_ok;
    int          seen;
    logic [31:0] r0;
    logic [2:0]  f;
    logic [31:0] a, b;

    checks = 0;
    errors = 0;
    bp_stop = 0;
    rst_n        = 1'b0;
    bus.Valid_in = 1'b0;
    bus.Rs1      = '0;
    bus.Rs2      = '0;
    bus.Funct3   = '0;
    bus.Flush    = 1'b0;
    bus.Ready_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.Ready_out), 32'd1);
    chk("rst_valid", 32'(bus.Valid_out), 32'd0);
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    chk("rst_result", bus.Result, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency, busy window and DONE stall
    bus.Ready_in = 1'b0;
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1);
    first   = 0;
    busy_ok = 1;
    for (int c = 1; c <= 40 && first == 0; c++) begin
      @(negedge clk);
      if (!bus.Busy) busy_ok = 0;
      if (bus.Valid_out) first = c;
      else begin
        @(posedge clk);
        #1;
      end
    end
    chk("latency", 32'(first), 32'd33);
    chk("busy_window", 32'(busy_ok), 32'd1);
    r0       = bus.Result;
    stall_ok = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (!bus.Valid_out || bus.Ready_out || bus.Result !== r0)
        stall_ok = 0;
    end
    chk("stall_stable", 32'(stall_ok), 32'd1);
    @(posedge clk);
    #1;
    bus.Ready_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("release_ready", 32'(bus.Ready_out), 32'd1);
    chk("release_busy", 32'(bus.Busy), 32'd0);
    @(posedge clk);
    #1;

    dir.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
    dir.push_back('{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0});
    dir.push_back('{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
    dir.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD});
    dir.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF});
    dir.push_back('{3'd5, 32'h8000_0000, 32'd2, 32'h4000_0000});
    dir.push_back('{3'd4, 32'h1234, 32'd0, 32'hFFFF_FFFF});
    dir.push_back('{3'd6, 32'h1234, 32'd0, 32'h1234});
    dir.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
    dir.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0});
    dir.push_back('{3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF});
    dir.push_back('{3'd7, 32'd5, 32'd0, 32'd5});
    dir.push_back('{3'd4, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF});
    dir.push_back('{3'd0, 32'd0, 32'h1234_5678, 32'h0});
    dir.push_back('{3'd1, 32'hFFFF_FFFF, 32'd0, 32'h0});
    foreach (dir[i])
      issue(dir[i].f, dir[i].a, dir[i].b, dir[i].e, 1);
    drain();

    // Flush mid-CALC, then back-to-back requests
    issue(3'd0, 32'h1111_1111, 32'h2222_2222, 32'h0, 0);
    repeat (9) @(posedge clk);
    #1;
    bus.Flush = 1'b1;
    @(posedge clk);
    #1;
    bus.Flush = 1'b0;
    chk("flush_busy", 32'(bus.Busy), 32'd0);
    chk("flush_ready", 32'(bus.Ready_out), 32'd1);
    chk("flush_valid", 32'(bus.Valid_out), 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.Valid_out) seen++;
    end
    chk("flush_no_result", 32'(seen), 32'd0);
    @(posedge clk);
    #1;
    issue(3'd5, 32'd1000, 32'd7, 32'd142, 1);
    issue(3'd7, 32'd1000, 32'd7, 32'd6, 1);
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1);
    drain();

    // Asynchronous reset in the middle of CALC
    issue(3'd4, 32'h0123_4567, 32'd3, 32'h0, 0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.Busy), 32'd0);
    chk("arst_ready", 32'(bus.Ready_out), 32'd1);
    chk("arst_valid", 32'(bus.Valid_out), 32'd0);
    chk("arst_result", bus.Result, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic with consumer backpressure
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          f = 3'($urandom);
          a = rnd_op();
          b = rnd_op();
          issue(f, a, b, model(f, a, b), 1);
        end
        drain();
        bp_stop = 1;
      end
      begin
        while (!bp_stop) begin
          @(posedge clk);
          #1;
          bus.Ready_in = ($urandom_range(0, 3) != 0);
        end
        bus.Ready_in = 1'b1;
      end
    join

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Parametrised, iterative execute-stage unit for the RV32M/RV64M multiply/divide instructions.
- Sits beside the combinational ALU and shares its operand and Funct3 inputs.
- Accepts one operation per valid/ready handshake, computes it over XLEN cycles with radix-2 shift-add or restoring division, and holds the result until the consumer takes it.
- Supports flush from the pipeline.

Parameters:
- XLEN, 32, operand and result width; must be a power of two, 8 or greater.
- CNT_W, $clog2(XLEN)+1, iteration counter width; derived, not overridden.

Ports:
- CLK  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Valid_in  in  1  operation request.
- Ready_out  out  1  unit can accept a request this cycle.
- Rs1  in  XLEN  multiplicand / dividend.
- Rs2  in  XLEN  multiplier / divisor.
- Funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Flush  in  1  abort any in-flight operation.
- Valid_out  out  1  Result is valid.
- Ready_in  in  1  consumer accepts Result.
- Result  out  XLEN  selected product half, quotient or remainder.
- Busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (CLK, rst_n). All state registers clear. State=IDLE, Ready_out=1, Valid_out=0, Busy=0, Result=0.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - Ready_out=1.
  - Valid_in=1 → latch Funct3 and operand absolute values, record result sign, clear accumulator, counter=XLEN, go to CALC.
- Operand signing:
  - Rs1 is signed for MULH, MULHSU, DIV and REM.
  - Rs2 is signed for MULH, DIV and REM.
  - MUL is sign-agnostic (low half only).
- CALC: one iteration per cycle, counter decrements; counter reaches 1 → go to DONE.
  - Multiply: 2*XLEN-bit product register.
  - Divide: restoring step on an XLEN+1-bit partial remainder.
- DONE:
  - Apply sign correction to the result.
  - Valid_out=1; Result stable until Ready_in=1, then go to IDLE.
  - Ready_out=0 in DONE; no same-cycle re-accept.
- Latency: accept at cycle 0; Valid_out first high at cycle XLEN+1.
- Result selection:
  - MUL = product[XLEN-1:0]; MULH* = product[2XLEN-1:XLEN].
  - Quotient sign = sign(Rs1) XOR sign(Rs2).
  - Remainder sign = sign(Rs1).
- Divide by zero: quotient = all ones (DIV and DIVU); remainder = Rs1 unmodified.
- Signed overflow (Rs1 = most negative, Rs2 = -1, DIV/REM): quotient = most negative, remainder = 0.
- Flush, any state: next cycle state=IDLE, Valid_out=0. No result is produced.
- Flush has priority over Valid_in and over Ready_in.
- Valid_in while not IDLE is ignored; upstream must hold Valid_in until Ready_out.
- Operand inputs are sampled only on acceptance; later changes have no effect.

Optional Feature:
- Macro MDU_FAST_PATH_EN.
- Defined: the following cases go IDLE→DONE directly (Valid_out at cycle 1), bypassing CALC:
  - divide by zero;
  - signed overflow;
  - multiply with either operand 0.
- Undefined: these cases take the full XLEN+1 cycles and give identical Result values.

Decomposition:
- Package mdu_pkg holds:
  - Funct3 opcode localparams (MDU_MUL … MDU_REMU);
  - FSM state encoding (IDLE=2'b00, CALC=2'b01, DONE=2'b10);
  - helper function is_signed_op.
- One sub-module: mdu_sign_fix. Combinational negate/select stage producing the final Result from the raw magnitude and the sign flags; reused for operand absolute value.

Test Plan:
- MUL Rs1=7, Rs2=-3 → Result=0xFFFFFFEB. Valid_out at cycle 33; Busy high cycles 1–33.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULH same operands → 0x00000000. MULHSU Rs1=-1, Rs2=0xFFFFFFFF → 0xFFFFFFFF.
- DIV -7/2 → -3 (0xFFFFFFFD). REM -7/2 → -1. DIVU 0x80000000/2 → 0x40000000.
- DIV x/0 → 0xFFFFFFFF; REM x/0 → x (x=0x1234). DIV 0x80000000/-1 → 0x80000000; REM → 0.
- Hold Ready_in=0 for 5 cycles in DONE → Result and Valid_out stable, Ready_out=0. Ready_in=1 → next cycle IDLE, Ready_out=1.
- Flush at CALC cycle 10 → next cycle IDLE, no Valid_out. Back-to-back new request completes correctly. rst_n low mid-CALC → outputs go to reset values immediately.
